tvip_axi_sample_responder: RTL and testbench

TVIP_AXI_SAMPLE_RESPONDER -- requirements
Module: tvip_axi_sample_responder

---
 rtl/tvip_axi_sample_responder_if.sv | 73 +++++++
 rtl/tvip_axi_sample_responder.sv | 215 +++++++++++++++++++++
 tb/tb_tvip_axi_sample_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tvip_axi_sample_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tvip_axi_types_pkg / tvip_axi_if                              |
// | Description : AXI field types and the AXI bus interface used by the          |
// |               sample responder.                                             |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package tvip_axi_types_pkg;
    localparam int TVIP_AXI_ID_WIDTH   = 4;
    localparam int TVIP_AXI_ADDR_WIDTH = 32;
    localparam int TVIP_AXI_DATA_WIDTH = 32;
    localparam int TVIP_AXI_STRB_WIDTH = TVIP_AXI_DATA_WIDTH / 8;

    typedef logic [TVIP_AXI_ID_WIDTH-1:0]   tvip_axi_id;
    typedef logic [TVIP_AXI_ADDR_WIDTH-1:0] tvip_axi_address;
    typedef logic [TVIP_AXI_DATA_WIDTH-1:0] tvip_axi_data;
    typedef logic [TVIP_AXI_STRB_WIDTH-1:0] tvip_axi_strobe;
    typedef logic [7:0]                     tvip_axi_burst_length;
    typedef logic [2:0]                     tvip_axi_burst_size;
    typedef logic [1:0]                     tvip_axi_burst_type;
    typedef logic [1:0]                     tvip_axi_response;
endpackage

interface tvip_axi_if;
    import tvip_axi_types_pkg::*;

    logic                 awvalid;
    logic                 awready;
    tvip_axi_id           awid;
    tvip_axi_address      awaddr;
    tvip_axi_burst_length awlen;
    tvip_axi_burst_size   awsize;
    tvip_axi_burst_type   awburst;
    logic                 wvalid;
    logic                 wready;
    tvip_axi_data         wdata;
    tvip_axi_strobe       wstrb;
    logic                 wlast;
    logic                 bvalid;
    logic                 bready;
    tvip_axi_id           bid;
    tvip_axi_response     bresp;
    logic                 arvalid;
    logic                 arready;
    tvip_axi_id           arid;
    tvip_axi_address      araddr;
    tvip_axi_burst_length arlen;
    tvip_axi_burst_size   arsize;
    tvip_axi_burst_type   arburst;
    logic                 rvalid;
    logic                 rready;
    tvip_axi_id           rid;
    tvip_axi_data         rdata;
    tvip_axi_response     rresp;
    logic                 rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface
`default_nettype wire

// File: rtl/tvip_axi_sample_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tvip_axi_sample_responder                                     |
// | Description : AXI slave backed by a word memory; independent write and read |
// |               FSMs. Define TVIP_AXI_SAMPLE_RESPONDER_ERROR_EN to answer     |
// |               SLVERR for bursts starting beyond the memory.                 |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tvip_axi_sample_responder
    import tvip_axi_types_pkg::*;
#(
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    tvip_axi_if.slave slave_if
);

    localparam int                 c_BYTES    = TVIP_AXI_DATA_WIDTH / 8;
    localparam int                 c_ADDR_LSB = $clog2(c_BYTES);
    localparam int                 c_IDX_W    = $clog2(MEMORY_DEPTH);
    localparam tvip_axi_response   c_OKAY     = 2'b00;
    localparam tvip_axi_response   c_SLVERR   = 2'b10;
    localparam tvip_axi_burst_type c_FIXED    = 2'b00;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    function automatic logic [c_IDX_W-1:0] word_index(input tvip_axi_address a);
        return c_IDX_W'(a >> c_ADDR_LSB);
    endfunction

    // WRAP bursts are stepped like INCR.
    function automatic tvip_axi_address next_addr(input tvip_axi_address a,
                                                  input tvip_axi_burst_size s,
                                                  input tvip_axi_burst_type b);
        return (b == c_FIXED) ? a : a + (TVIP_AXI_ADDR_WIDTH'(1) << s);
    endfunction

    tvip_axi_data mem [MEMORY_DEPTH];

    w_state_e           w_state_q, w_state_d;
    tvip_axi_id         awid_q, awid_d;
    tvip_axi_address    waddr_q, waddr_d;
    tvip_axi_burst_size awsize_q, awsize_d;
    tvip_axi_burst_type awburst_q, awburst_d;
    logic               werr_q, werr_d;

    r_state_e             r_state_q, r_state_d;
    tvip_axi_id           arid_q, arid_d;
    tvip_axi_address      raddr_q, raddr_d;
    tvip_axi_burst_size   arsize_q, arsize_d;
    tvip_axi_burst_type   arburst_q, arburst_d;
    tvip_axi_burst_length arlen_q, arlen_d;
    tvip_axi_burst_length rbeat_q, rbeat_d;
    logic                 rerr_q, rerr_d;
    tvip_axi_data         rdata_q, rdata_d;

    logic            w_aw_err;
    logic            w_ar_err;
    logic            w_mem_we;
    logic            w_rlast;
    tvip_axi_address w_rd_addr;
    tvip_axi_data    w_rd_word;

`ifdef TVIP_AXI_SAMPLE_RESPONDER_ERROR_EN
    assign w_aw_err = (slave_if.awaddr >> c_ADDR_LSB) >= TVIP_AXI_ADDR_WIDTH'(MEMORY_DEPTH);
    assign w_ar_err = (slave_if.araddr >> c_ADDR_LSB) >= TVIP_AXI_ADDR_WIDTH'(MEMORY_DEPTH);
`else
    assign w_aw_err = 1'b0;
    assign w_ar_err = 1'b0;
`endif

    always_comb begin
        w_state_d = w_state_q;
        awid_d    = awid_q;
        waddr_d   = waddr_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        werr_d    = werr_q;
        case (w_state_q)
            W_IDLE: begin
                if (slave_if.awvalid) begin
                    awid_d    = slave_if.awid;
                    waddr_d   = slave_if.awaddr;
                    awsize_d  = slave_if.awsize;
                    awburst_d = slave_if.awburst;
                    werr_d    = w_aw_err;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (slave_if.wvalid) begin
                    waddr_d = next_addr(waddr_q, awsize_q, awburst_q);
                    if (slave_if.wlast) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (slave_if.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign w_mem_we = (w_state_q == W_DATA) && slave_if.wvalid && !werr_q;

    // Write lanes land at the clock edge, so a read captured in the same cycle sees old data.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (slave_if.wstrb[b]) begin
                    mem[word_index(waddr_q)][b*8 +: 8] <= slave_if.wdata[b*8 +: 8];
                end
            end
        end
    end

    assign w_rd_addr = (r_state_q == R_IDLE) ? slave_if.araddr
                                             : next_addr(raddr_q, arsize_q, arburst_q);
    assign w_rd_word = mem[word_index(w_rd_addr)];
    assign w_rlast   = (r_state_q == R_DATA) && (rbeat_q == arlen_q);

    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        raddr_d   = raddr_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        arlen_d   = arlen_q;
        rbeat_d   = rbeat_q;
        rerr_d    = rerr_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (slave_if.arvalid) begin
                    arid_d    = slave_if.arid;
                    raddr_d   = slave_if.araddr;
                    arsize_d  = slave_if.arsize;
                    arburst_d = slave_if.arburst;
                    arlen_d   = slave_if.arlen;
                    rbeat_d   = '0;
                    rerr_d    = w_ar_err;
                    rdata_d   = w_ar_err ? '0 : w_rd_word;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (slave_if.rready) begin
                    if (w_rlast) begin
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d = w_rd_addr;
                        rbeat_d = rbeat_q + 8'd1;
                        rdata_d = rerr_q ? '0 : w_rd_word;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            waddr_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            raddr_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            arlen_q   <= '0;
            rbeat_q   <= '0;
            rerr_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awid_q    <= awid_d;
            waddr_q   <= waddr_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            arid_q    <= arid_d;
            raddr_q   <= raddr_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            arlen_q   <= arlen_d;
            rbeat_q   <= rbeat_d;
            rerr_q    <= rerr_d;
            rdata_q   <= rdata_d;
        end
    end

    assign slave_if.awready = (w_state_q == W_IDLE);
    assign slave_if.wready  = (w_state_q == W_DATA);
    assign slave_if.bvalid  = (w_state_q == W_RESP);
    assign slave_if.bid     = awid_q;
    assign slave_if.bresp   = werr_q ? c_SLVERR : c_OKAY;
    assign slave_if.arready = (r_state_q == R_IDLE);
    assign slave_if.rvalid  = (r_state_q == R_DATA);
    assign slave_if.rid     = arid_q;
    assign slave_if.rdata   = rdata_q;
    assign slave_if.rresp   = rerr_q ? c_SLVERR : c_OKAY;
    assign slave_if.rlast   = w_rlast;

endmodule
`default_nettype wire

// File: tb/tb_tvip_axi_sample_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tvip_axi_sample_responder                                  |
// | Description : Directed and random AXI traffic against a word-level memory   |
// |               model of the sample responder.                                |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_tvip_axi_sample_responder;
    import tvip_axi_types_pkg::*;

    localparam int c_DEPTH = 64;
`ifdef TVIP_AXI_SAMPLE_RESPONDER_ERROR_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tvip_axi_if axi ();

    tvip_axi_sample_responder #(.MEMORY_DEPTH(c_DEPTH)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .slave_if (axi)
    );

    logic [31:0] mem_m [c_DEPTH];
    logic [31:0] wd_a  [256];
    logic [3:0]  ws_a  [256];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit flagged(input logic [31:0] a);
        return c_ERR_EN && ((a >> 2) >= 32'(c_DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % c_DEPTH);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i,
                                              input logic [2:0] size, input logic [1:0] burst);
        return (burst == 2'b00) ? start : start + 32'(i) * (32'd1 << size);
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input int bdelay);
        int  cyc;
        bit  err;
        int  idx;
        err = flagged(addr);
        axi.awvalid = 1'b1; axi.awid = id; axi.awaddr = addr;
        axi.awlen = 8'(len); axi.awsize = size; axi.awburst = burst;
        cyc = 0;
        while (!axi.awready && cyc < 50) begin step(); cyc++; end
        check("aw_ready", axi.awready, 1);
        step();
        axi.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            axi.wvalid = 1'b1; axi.wdata = wd_a[i]; axi.wstrb = ws_a[i]; axi.wlast = (i == len);
            cyc = 0;
            while (!axi.wready && cyc < 50) begin step(); cyc++; end
            check("w_ready", axi.wready, 1);
            step();
            if (!err) begin
                idx = widx(beat_addr(addr, i, size, burst));
                for (int b = 0; b < 4; b++)
                    if (ws_a[i][b]) mem_m[idx][b*8 +: 8] = wd_a[i][b*8 +: 8];
            end
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        for (int k = 0; k < bdelay; k++) begin
            check("b_hold_valid", axi.bvalid, 1);
            check("b_hold_awready", axi.awready, 0);
            step();
        end
        axi.bready = 1'b1;
        cyc = 0;
        while (!axi.bvalid && cyc < 50) begin step(); cyc++; end
        check("b_valid", axi.bvalid, 1);
        check("b_id", axi.bid, id);
        check("b_resp", axi.bresp, err ? 2'b10 : 2'b00);
        step();
        axi.bready = 1'b0;
        check("b_drop", axi.bvalid, 0);
        check("aw_ready_after_b", axi.awready, 1);
    endtask

    // rmode: 0 = always ready, 1 = toggle 1,0,1,0..., 2 = random
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int rmode);
        int          cyc;
        int          beat;
        bit          err;
        bit          rr;
        logic [31:0] exp_d;
        logic [31:0] h_data;
        logic        h_last;
        err = flagged(addr);
        axi.arvalid = 1'b1; axi.arid = id; axi.araddr = addr;
        axi.arlen = 8'(len); axi.arsize = size; axi.arburst = burst;
        cyc = 0;
        while (!axi.arready && cyc < 50) begin step(); cyc++; end
        check("ar_ready", axi.arready, 1);
        step();
        axi.arvalid = 1'b0;
        check("r_valid_after_ar", axi.rvalid, 1);
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 4000) begin
            case (rmode)
                0:       rr = 1'b1;
                1:       rr = (cyc % 2) == 0;
                default: rr = 1'($urandom);
            endcase
            axi.rready = rr;
            if (axi.rvalid && rr) begin
                exp_d = err ? 32'h0 : mem_m[widx(beat_addr(addr, beat, size, burst))];
                check("r_data", axi.rdata, exp_d);
                check("r_id", axi.rid, id);
                check("r_resp", axi.rresp, err ? 2'b10 : 2'b00);
                check("r_last", axi.rlast, beat == len);
                beat++;
                step();
            end else if (axi.rvalid) begin
                h_data = axi.rdata;
                h_last = axi.rlast;
                step();
                check("r_stall_valid", axi.rvalid, 1);
                check("r_stall_data", axi.rdata, h_data);
                check("r_stall_last", axi.rlast, h_last);
                check("r_stall_id", axi.rid, id);
            end else begin
                step();
            end
            cyc++;
        end
        axi.rready = 1'b0;
        check("r_beats", beat, len + 1);
        check("r_idle_after", axi.rvalid, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          len;
        axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
        axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
        axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
        axi.rready = 0;

        repeat (3) step();
        check("rst_awready", axi.awready, 1);
        check("rst_arready", axi.arready, 1);
        check("rst_wready", axi.wready, 0);
        check("rst_bvalid", axi.bvalid, 0);
        check("rst_rvalid", axi.rvalid, 0);
        check("rst_rdata", axi.rdata, 0);
        rst_n = 1'b1;
        step();

        // Fill every word so the model starts from known contents.
        for (int i = 0; i < c_DEPTH; i++) begin wd_a[i] = $urandom; ws_a[i] = 4'hF; end
        axi_write(4'd1, 32'h0, c_DEPTH - 1, 3'd2, 2'b01, 0);

        for (int i = 0; i < 4; i++) begin wd_a[i] = 32'hA0 + 32'(i); ws_a[i] = 4'hF; end
        axi_write(4'd3, 32'h40, 3, 3'd2, 2'b01, 0);
        axi_read(4'd5, 32'h40, 3, 3'd2, 2'b01, 0);

        wd_a[0] = 32'hFFFF_FFFF; ws_a[0] = 4'hF;
        axi_write(4'd0, 32'h0, 0, 3'd2, 2'b01, 0);
        wd_a[0] = 32'h0; ws_a[0] = 4'b0001;
        axi_write(4'd0, 32'h0, 0, 3'd2, 2'b01, 0);
        axi_read(4'd0, 32'h0, 0, 3'd2, 2'b01, 0);

        axi_read(4'd6, 32'h0, 7, 3'd2, 2'b01, 1);

        wd_a[0] = 32'h1234_5678; ws_a[0] = 4'hF;
        axi_write(4'd2, 32'h20, 0, 3'd2, 2'b01, 10);

        wd_a[0] = 32'h5A5A_C3C3; ws_a[0] = 4'hF;
        axi_write(4'd4, 32'(c_DEPTH * 4), 0, 3'd2, 2'b01, 0);
        axi_read(4'd4, 32'h0, 0, 3'd2, 2'b01, 0);

        axi_read(4'd9, 32'h10, 3, 3'd2, 2'b00, 0);

        for (int t = 0; t < 40; t++) begin
            a   = 32'($urandom_range(0, c_DEPTH * 8 - 1));
            len = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= len; i++) begin wd_a[i] = $urandom; ws_a[i] = 4'($urandom); end
                axi_write(4'($urandom), a, len, 3'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)));
            end else begin
                axi_read(4'($urandom), a, len, 3'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 2);
            end
        end

        // Reset in the middle of a write burst and an outstanding read.
        axi.awvalid = 1; axi.awid = 4'd2; axi.awaddr = 32'h8; axi.awlen = 8'd3;
        axi.awsize = 3'd2; axi.awburst = 2'b01;
        step();
        axi.awvalid = 0;
        axi.wvalid = 1; axi.wdata = 32'hDEAD_BEEF; axi.wstrb = 4'hF; axi.wlast = 0;
        check("mid_wready", axi.wready, 1);
        step();
        axi.wvalid = 0;
        mem_m[2] = 32'hDEAD_BEEF;
        axi.arvalid = 1; axi.arid = 4'd7; axi.araddr = 32'h10; axi.arlen = 8'd3;
        axi.arsize = 3'd2; axi.arburst = 2'b01;
        step();
        axi.arvalid = 0;
        check("mid_rvalid", axi.rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_awready", axi.awready, 1);
        check("mrst_arready", axi.arready, 1);
        check("mrst_wready", axi.wready, 0);
        check("mrst_bvalid", axi.bvalid, 0);
        check("mrst_rvalid", axi.rvalid, 0);
        check("mrst_rlast", axi.rlast, 0);
        check("mrst_bid", axi.bid, 0);
        check("mrst_rid", axi.rid, 0);
        check("mrst_bresp", axi.bresp, 0);
        check("mrst_rresp", axi.rresp, 0);
        check("mrst_rdata", axi.rdata, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        axi_read(4'd1, 32'h8, 0, 3'd2, 2'b01, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
